round_ctrl: RTL and testbench
=============================

ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 The block SHALL have parameter TIME_LIMIT, default 16'd1000, answer window per round in CLK cycles.
REQ-002 The block SHALL have parameter N_ROUNDS, default 8'd10, rounds per game (legal 1..255).
REQ-003 The block SHALL have port CLK  input  1  sole clock; all state updates on posedge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port START  input  1  level request to begin a game.
REQ-006 The block SHALL have port MINE_RES  input  2  own judge result: 00 none, 01 correct, 10 wrong, 11 reserved (treated as 00).
REQ-007 The block SHALL have port ENEMY_RES  input  2  opponent judge result, same encoding as MINE_RES.
REQ-008 The block SHALL have port HP_ACK  input  1  HP manager has consumed WL_OUT.
REQ-009 The block SHALL have port Q_REQ  output  1  one-cycle pulse requesting the next question.
REQ-010 The block SHALL have port ROUND_ACTIVE  output  1  high while the answer window is open.
REQ-011 The block SHALL have port WL_OUT  output  2  round result: 00 no winner, 01 own win, 10 enemy win, 11 draw.
REQ-012 The block SHALL have port WL_VALID  output  1  WL_OUT is valid for the HP manager.
REQ-013 The block SHALL have port ROUND_CNT  output  8  number of completed rounds in the current game.
REQ-014 The block SHALL have port TIME_LEFT  output  16  remaining cycles in the answer window.
REQ-015 The block SHALL have port GAME_END  output  1  high once N_ROUNDS rounds have completed.

Function
REQ-016 The block SHALL implement states IDLE, ASK, WAIT, REPORT, DONE.
REQ-017 IDLE: with START=1 the block SHALL clear ROUND_CNT to 0 and move to ASK on the next edge.
REQ-018 ASK: the block SHALL assert Q_REQ for exactly this one cycle, load TIME_LEFT=TIME_LIMIT and move to WAIT.
REQ-019 WAIT: the block SHALL assert ROUND_ACTIVE and decrement TIME_LEFT by 1 per cycle while it is nonzero, never wrapping below 0.
REQ-020 WAIT: both inputs 01 in the same cycle SHALL register WL_OUT=11; MINE_RES=01 alone SHALL register 01; ENEMY_RES=01 alone SHALL register 10; the block then moves to REPORT.
REQ-021 WAIT: result 10 (wrong) SHALL be ignored and the window SHALL stay open, so the player may retry.
REQ-022 WAIT: when TIME_LEFT==0 and neither input is 01, the block SHALL register WL_OUT=00 and move to REPORT, i.e. TIME_LIMIT+1 cycles after entering WAIT.
REQ-023 A correct answer in the same cycle as TIME_LEFT==0 SHALL take priority over timeout.
REQ-024 REPORT: WL_VALID SHALL be 1 and WL_OUT stable until HP_ACK=1; the cycle HP_ACK is sampled high SHALL increment ROUND_CNT.
REQ-025 REPORT with HP_ACK: if the incremented ROUND_CNT equals N_ROUNDS the block SHALL move to DONE, else to ASK.
REQ-026 HP_ACK outside REPORT SHALL be ignored; MINE_RES/ENEMY_RES outside WAIT SHALL be ignored.
REQ-027 DONE: GAME_END SHALL be 1; the block SHALL stay in DONE while START=1, and SHALL return to IDLE when START=0.
REQ-028 WL_OUT SHALL hold its last value outside REPORT until overwritten by the next WAIT exit.
REQ-029 Deasserting START mid-game SHALL NOT abort the game.

Reset
REQ-030 RST=1 SHALL immediately force state IDLE, Q_REQ=0, ROUND_ACTIVE=0, WL_OUT=00, WL_VALID=0, ROUND_CNT=0, TIME_LEFT=0 and GAME_END=0, regardless of CLK, including mid-round.
REQ-031 After RST falls, the block SHALL require START=1 in IDLE to begin a game.

Structure
REQ-032 Package quiz_pkg SHALL hold the state enumeration, the WL codes (WL_NONE, WL_MINE, WL_ENEMY, WL_DRAW) and the judge-result codes (RES_NONE, RES_OK, RES_NG).
REQ-033 A sub-module round_timer (16-bit loadable, saturating down-counter with zero flag) SHALL implement TIME_LEFT.

Verification
REQ-034 TIME_LIMIT=20, START=1, MINE_RES=01 at WAIT cycle 5 -> WL_OUT=01 and WL_VALID=1 next cycle; HP_ACK -> ROUND_CNT=1 and Q_REQ pulse.
REQ-035 Both inputs =01 in the same cycle -> WL_OUT=11; ENEMY_RES=10 then MINE_RES=01 -> WL_OUT=01 (the wrong answer is ignored).
REQ-036 TIME_LIMIT=20 with no answers -> WL_OUT=00, WL_VALID rises 21 cycles after entering WAIT; ENEMY_RES=01 exactly at TIME_LEFT==0 -> WL_OUT=10.
REQ-037 N_ROUNDS=3 with three acked rounds -> GAME_END=1, ROUND_CNT=3; START low -> IDLE; START high -> ROUND_CNT=0 and a Q_REQ pulse.
REQ-038 WL_VALID held 10 cycles with no HP_ACK -> WL_OUT stable and ROUND_CNT unchanged; RST pulsed mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/quiz_pkg.sv
`default_nettype none
// ============================================================================
// quiz_pkg : shared state encoding, round-result and judge-result codes
// Rev 1.0  : initial release
// ============================================================================
package quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ASK    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] WL_NONE  = 2'b00;
  localparam logic [1:0] WL_MINE  = 2'b01;
  localparam logic [1:0] WL_ENEMY = 2'b10;
  localparam logic [1:0] WL_DRAW  = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_OK   = 2'b01;
  localparam logic [1:0] RES_NG   = 2'b10;

  // Bit 0 flags our win, bit 1 the opponent's; both set encodes a draw.
  function automatic logic [1:0] judge_wl(input logic mine_ok, input logic enemy_ok);
    return {enemy_ok, mine_ok};
  endfunction

endpackage

`default_nettype wire

// File: rtl/round_timer.sv
`default_nettype none
// ============================================================================
// round_timer : loadable down-counter that saturates at zero, with zero flag
// Rev 1.0     : initial release
// ============================================================================
module round_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/round_ctrl.sv
`default_nettype none
// ============================================================================
// round_ctrl : quiz game sequencer - asks questions, times the answer window,
//              reports the round winner and counts rounds to game end
// Rev 1.0    : initial release
// ============================================================================
module round_ctrl
  import quiz_pkg::*;
#(
  parameter logic [15:0] TIME_LIMIT = 16'd1000,
  parameter logic [7:0]  N_ROUNDS   = 8'd10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  MINE_RES,
  input  logic [1:0]  ENEMY_RES,
  input  logic        HP_ACK,
  output logic        Q_REQ,
  output logic        ROUND_ACTIVE,
  output logic [1:0]  WL_OUT,
  output logic        WL_VALID,
  output logic [7:0]  ROUND_CNT,
  output logic [15:0] TIME_LEFT,
  output logic        GAME_END
);

  state_t      state_q, state_d;
  logic [1:0]  wl_q, wl_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;
  logic        mine_ok, enemy_ok;
  logic        timer_load, timer_dec, timer_zero;

  // Only an exact "correct" code counts; wrong and reserved are both ignored.
  assign mine_ok  = (MINE_RES  == RES_OK);
  assign enemy_ok = (ENEMY_RES == RES_OK);
  assign cnt_inc  = cnt_q + 8'd1;

  round_timer #(
    .WIDTH(16)
  ) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .load_i    (timer_load),
    .load_val_i(TIME_LIMIT),
    .dec_i     (timer_dec),
    .count_o   (TIME_LEFT),
    .zero_o    (timer_zero)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      wl_q    <= WL_NONE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wl_q    <= wl_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wl_d    = wl_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          cnt_d   = 8'd0;
          state_d = ST_ASK;
        end
      end
      ST_ASK: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A correct answer wins over an expiring window in the same cycle.
        if (mine_ok || enemy_ok) begin
          wl_d    = judge_wl(mine_ok, enemy_ok);
          state_d = ST_REPORT;
        end else if (timer_zero) begin
          wl_d    = WL_NONE;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (HP_ACK) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == N_ROUNDS) ? ST_DONE : ST_ASK;
        end
      end
      ST_DONE: begin
        if (!START) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    Q_REQ        = (state_q == ST_ASK);
    ROUND_ACTIVE = (state_q == ST_WAIT);
    WL_VALID     = (state_q == ST_REPORT);
    GAME_END     = (state_q == ST_DONE);
    timer_load   = (state_q == ST_ASK);
    timer_dec    = (state_q == ST_WAIT);
  end

  assign WL_OUT    = wl_q;
  assign ROUND_CNT = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_round_ctrl.sv
`default_nettype none
// ============================================================================
// tb_round_ctrl : directed stimulus with a queue-based round-result scoreboard
// Rev 1.0       : initial release
// ============================================================================
module tb_round_ctrl;
  import quiz_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [1:0]  MINE_RES;
  logic [1:0]  ENEMY_RES;
  logic        HP_ACK;
  logic        Q_REQ;
  logic        ROUND_ACTIVE;
  logic [1:0]  WL_OUT;
  logic        WL_VALID;
  logic [7:0]  ROUND_CNT;
  logic [15:0] TIME_LEFT;
  logic        GAME_END;

  typedef struct {
    logic [1:0] wl;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  round_ctrl #(
    .TIME_LIMIT(16'd20),
    .N_ROUNDS  (8'd3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .MINE_RES    (MINE_RES),
    .ENEMY_RES   (ENEMY_RES),
    .HP_ACK      (HP_ACK),
    .Q_REQ       (Q_REQ),
    .ROUND_ACTIVE(ROUND_ACTIVE),
    .WL_OUT      (WL_OUT),
    .WL_VALID    (WL_VALID),
    .ROUND_CNT   (ROUND_CNT),
    .TIME_LEFT   (TIME_LEFT),
    .GAME_END    (GAME_END)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic ack();
    HP_ACK = 1'b1;
    step(1);
    HP_ACK = 1'b0;
  endtask

  // Monitor: measures window length and checks each reported result.
  logic prev_act = 1'b0;
  logic prev_val = 1'b0;
  int   act_cnt  = 0;

  always @(negedge CLK) begin
    if (RST) begin
      prev_act = 1'b0;
      prev_val = 1'b0;
      act_cnt  = 0;
    end else begin
      if (ROUND_ACTIVE) act_cnt = prev_act ? act_cnt + 1 : 1;
      if (WL_VALID && !prev_val) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_report: got WL_OUT=%0d, expected no report", WL_OUT);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wl_out", {30'd0, WL_OUT}, {30'd0, e.wl});
          chk("window_len", act_cnt, e.cyc);
        end
      end
      prev_act = ROUND_ACTIVE;
      prev_val = WL_VALID;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    START     = 1'b0;
    MINE_RES  = RES_NONE;
    ENEMY_RES = RES_NONE;
    HP_ACK    = 1'b0;
    #12;
    chk("reset_outputs", {2'd0, Q_REQ, ROUND_ACTIVE, WL_OUT, WL_VALID, ROUND_CNT, TIME_LEFT, GAME_END}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    step(3);
    chk("idle_needs_start", {29'd0, Q_REQ, ROUND_ACTIVE, GAME_END}, 32'd0);

    // Game 1, round 1: own correct answer at window cycle 5
    START = 1'b1;
    step(1);
    chk("ask_qreq", Q_REQ, 1);
    chk("ask_cnt_cleared", ROUND_CNT, 0);
    step(1);
    chk("wait_entry", {14'd0, Q_REQ, ROUND_ACTIVE, TIME_LEFT}, {16'd1, 16'd20});
    exp_q.push_back('{WL_MINE, 6});
    step(5);
    chk("time_left_c5", TIME_LEFT, 15);
    MINE_RES = RES_OK;
    step(1);
    MINE_RES = RES_NONE;
    chk("report_valid", WL_VALID, 1);
    ack();
    chk("ack_cnt1_qreq", {23'd0, ROUND_CNT, Q_REQ}, {23'd0, 8'd1, 1'b1});
    START = 1'b0;

    // Round 2: wrong answer ignored, then own correct; report held without ack
    step(1);
    exp_q.push_back('{WL_MINE, 5});
    step(2);
    ENEMY_RES = RES_NG;
    step(1);
    ENEMY_RES = RES_NONE;
    chk("ng_ignored", ROUND_ACTIVE, 1);
    step(1);
    MINE_RES = RES_OK;
    step(1);
    MINE_RES = RES_NONE;
    step(10);
    chk("report_hold", {21'd0, WL_VALID, WL_OUT, ROUND_CNT}, {21'd0, 1'b1, 2'b01, 8'd1});
    ack();

    // Round 3: simultaneous answers give a draw; game ends
    step(1);
    exp_q.push_back('{WL_DRAW, 1});
    MINE_RES  = RES_OK;
    ENEMY_RES = RES_OK;
    step(1);
    MINE_RES  = RES_NONE;
    ENEMY_RES = RES_NONE;
    START = 1'b1;
    ack();
    chk("done_end_cnt", {23'd0, GAME_END, ROUND_CNT}, {23'd0, 1'b1, 8'd3});
    step(2);
    chk("done_stays_wl_held", {29'd0, GAME_END, WL_OUT}, {29'd0, 1'b1, 2'b11});
    START = 1'b0;
    step(1);
    chk("back_to_idle", {30'd0, GAME_END, Q_REQ}, 32'd0);
    HP_ACK = 1'b1;
    step(1);
    HP_ACK = 1'b0;
    chk("ack_ignored_idle", ROUND_CNT, 3);
    START = 1'b1;
    step(1);
    chk("restart_cnt_qreq", {23'd0, ROUND_CNT, Q_REQ}, {23'd0, 8'd0, 1'b1});
    START = 1'b0;

    // Game 2, round 1: timeout with no answers
    step(1);
    exp_q.push_back('{WL_NONE, 21});
    step(20);
    chk("last_window_cycle", {15'd0, ROUND_ACTIVE, TIME_LEFT}, {15'd0, 1'b1, 16'd0});
    step(1);
    chk("timeout_report", {15'd0, WL_VALID, TIME_LEFT}, {15'd0, 1'b1, 16'd0});
    ack();

    // Round 2: opponent correct exactly when the window reaches zero
    step(1);
    exp_q.push_back('{WL_ENEMY, 21});
    step(20);
    ENEMY_RES = RES_OK;
    step(1);
    ENEMY_RES = RES_NONE;
    chk("late_answer_report", WL_VALID, 1);
    ack();

    // Round 3: reset mid-window
    step(1);
    step(3);
    #2;
    RST = 1'b1;
    #1;
    chk("async_reset_outputs", {2'd0, Q_REQ, ROUND_ACTIVE, WL_OUT, WL_VALID, ROUND_CNT, TIME_LEFT, GAME_END}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    step(3);
    chk("idle_after_reset", {29'd0, Q_REQ, ROUND_ACTIVE, WL_VALID}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
